// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit PHT counter states,
// the counter reset value and the saturating counter update.
// No ports; imported by the predictor top.
package bp_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,  // strong not-taken
        CTR_WNT = 2'b01,  // weak not-taken
        CTR_WT  = 2'b10,  // weak taken
        CTR_ST  = 2'b11   // strong taken
    } counter_t;

    localparam logic [1:0] PHT_RESET = 2'b01;

    // Move a counter one step toward the resolved outcome, saturating at the ends.
    function automatic counter_t sat_update(counter_t c, logic taken);
        logic [1:0] v;
        v = c;
        if (taken) begin
            if (v != 2'b11) v = v + 2'd1;
        end else begin
            if (v != 2'b00) v = v - 2'd1;
        end
        return counter_t'(v);
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch lookup and decode training bundle between the pipeline and the predictor.
// master: pipeline side (drives fetch PC, stall and resolution info).
// slave: predictor side (returns direction, next PC and the history used).
interface gshare_predictor_if #(
    parameter int GHR_WIDTH = 8
);
    logic                 en;
    logic [31:0]          pc_f;
    logic                 pred_taken;
    logic [31:0]          pred_pc;
    logic [GHR_WIDTH-1:0] pred_ghr;
    logic                 upd_valid;
    logic [31:0]          upd_pc;
    logic                 upd_is_cond;
    logic                 upd_taken;
    logic [31:0]          upd_target;
    logic [GHR_WIDTH-1:0] upd_ghr;
    logic                 upd_mispredict;

    modport master (
        output en, pc_f, upd_valid, upd_pc, upd_is_cond, upd_taken,
               upd_target, upd_ghr, upd_mispredict,
        input  pred_taken, pred_pc, pred_ghr
    );

    modport slave (
        input  en, pc_f, upd_valid, upd_pc, upd_is_cond, upd_taken,
               upd_target, upd_ghr, upd_mispredict,
        output pred_taken, pred_pc, pred_ghr
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer held in flops; only valid bits are reset.
// Ports: combinational read (rd_pc -> hit, rd_target, rd_uncond);
// synchronous write (wr_en, wr_pc, wr_target, wr_uncond) committed at posedge clk.
module branch_target_buffer #(
    parameter int BTB_INDEX_WIDTH = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rd_pc,
    output logic        hit,
    output logic [31:0] rd_target,
    output logic        rd_uncond,
    input  logic        wr_en,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_target,
    input  logic        wr_uncond
);
    localparam int ENTRIES = 1 << BTB_INDEX_WIDTH;
    localparam int TAG_W   = 30 - BTB_INDEX_WIDTH;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic             uncond_q [ENTRIES];

    logic [BTB_INDEX_WIDTH-1:0] rd_idx;
    logic [BTB_INDEX_WIDTH-1:0] wr_idx;
    logic                       unused_low;

    // Instructions are word aligned, so the two low PC bits carry no information.
    assign unused_low = ^{rd_pc[1:0], wr_pc[1:0]};

    assign rd_idx    = rd_pc[BTB_INDEX_WIDTH+1:2];
    assign wr_idx    = wr_pc[BTB_INDEX_WIDTH+1:2];
    assign hit       = valid_q[rd_idx] && (tag_q[rd_idx] == rd_pc[31:BTB_INDEX_WIDTH+2]);
    assign rd_target = target_q[rd_idx];
    assign rd_uncond = uncond_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is never consulted while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]    <= wr_pc[31:BTB_INDEX_WIDTH+2];
            target_q[wr_idx] <= wr_target;
            uncond_q[wr_idx] <= wr_uncond;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor (PHT xor global history) plus BTB target lookup.
// Ports: clk, rst (sync, active-high), bp (slave): combinational prediction for pc_f,
// training and history repair from the decode-stage resolution fields.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int PHT_INDEX_WIDTH = 10,
    parameter int GHR_WIDTH       = 8,
    parameter int BTB_INDEX_WIDTH = 6
) (
    input  logic clk,
    input  logic rst,
    gshare_predictor_if.slave bp
);
    localparam int PHT_ENTRIES = 1 << PHT_INDEX_WIDTH;

    counter_t                   pht [PHT_ENTRIES];
    logic [GHR_WIDTH-1:0]       ghr;
    logic [PHT_INDEX_WIDTH-1:0] look_idx;
    logic [PHT_INDEX_WIDTH-1:0] upd_idx;
    logic [1:0]                 look_ctr;
    logic                       btb_hit;
    logic [31:0]                btb_target;
    logic                       btb_uncond;

    branch_target_buffer #(
        .BTB_INDEX_WIDTH(BTB_INDEX_WIDTH)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (bp.pc_f),
        .hit       (btb_hit),
        .rd_target (btb_target),
        .rd_uncond (btb_uncond),
        .wr_en     (bp.upd_valid && bp.upd_taken),
        .wr_pc     (bp.upd_pc),
        .wr_target (bp.upd_target),
        .wr_uncond (!bp.upd_is_cond)
    );

    // History is zero-extended into the upper index bits when shorter than the index.
    assign look_idx = bp.pc_f[PHT_INDEX_WIDTH+1:2] ^ PHT_INDEX_WIDTH'(ghr);
    assign upd_idx  = bp.upd_pc[PHT_INDEX_WIDTH+1:2] ^ PHT_INDEX_WIDTH'(bp.upd_ghr);
    assign look_ctr = pht[look_idx];

    assign bp.pred_taken = btb_hit && (btb_uncond || look_ctr[1]);
    assign bp.pred_pc    = bp.pred_taken ? btb_target : bp.pc_f + 32'd4;
    assign bp.pred_ghr   = ghr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= counter_t'(PHT_RESET);
        end else if (bp.upd_valid && bp.upd_is_cond) begin
            pht[upd_idx] <= sat_update(pht[upd_idx], bp.upd_taken);
        end
    end

    // Repair from a resolved mispredict wins over the speculative shift of the
    // current lookup, since that lookup lies on the wrong path.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (bp.upd_valid && bp.upd_mispredict) begin
            if (bp.upd_is_cond) ghr <= {bp.upd_ghr[GHR_WIDTH-2:0], bp.upd_taken};
            else                ghr <= bp.upd_ghr;
        end else if (bp.en && btb_hit && !btb_uncond) begin
            ghr <= {ghr[GHR_WIDTH-2:0], bp.pred_taken};
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gshare_predictor_if #(.GHR_WIDTH(8)) bif ();

    gshare_predictor #(
        .PHT_INDEX_WIDTH(10),
        .GHR_WIDTH      (8),
        .BTB_INDEX_WIDTH(6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bif)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: plain integers, indexed by the arithmetic of the rules.
    int          pht_m [1024];
    bit          bv_m  [64];
    int unsigned btag_m[64];
    int unsigned btgt_m[64];
    bit          bu_m  [64];
    int unsigned ghr_m;
    bit          model_ok = 0;

    logic        obs_taken;
    logic [31:0] obs_pc;
    logic [7:0]  obs_ghr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) pht_m[i] = 1;
        for (int i = 0; i < 64; i++) bv_m[i] = 0;
        ghr_m = 0;
        model_ok = 1;
    endtask

    // One clock cycle: drive, check the combinational prediction, then advance the model.
    task automatic cyc(input bit r, input bit e, input logic [31:0] pc,
                       input bit uv, input logic [31:0] upc, input bit uc, input bit ut,
                       input logic [31:0] utg, input logic [7:0] ug, input bit um);
        int unsigned bidx, pidx, uidx, ubidx;
        bit          m_hit, m_taken;
        int unsigned m_pc;
        rst                = r;
        bif.en             = e;
        bif.pc_f           = pc;
        bif.upd_valid      = uv;
        bif.upd_pc         = upc;
        bif.upd_is_cond    = uc;
        bif.upd_taken      = ut;
        bif.upd_target     = utg;
        bif.upd_ghr        = ug;
        bif.upd_mispredict = um;
        #1;
        bidx    = (pc / 4) % 64;
        m_hit   = bv_m[bidx] && (btag_m[bidx] == pc / 256);
        pidx    = ((pc / 4) ^ ghr_m) % 1024;
        m_taken = m_hit && (bu_m[bidx] || pht_m[pidx] >= 2);
        m_pc    = m_taken ? btgt_m[bidx] : pc + 4;
        obs_taken = bif.pred_taken;
        obs_pc    = bif.pred_pc;
        obs_ghr   = bif.pred_ghr;
        if (model_ok) begin
            chk("model_taken", 64'(obs_taken), 64'(m_taken));
            chk("model_pc",    64'(obs_pc),    64'(m_pc));
            chk("model_ghr",   64'(obs_ghr),   64'(ghr_m));
        end
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (uv && uc) begin
                uidx = ((upc / 4) ^ ug) % 1024;
                if (ut) pht_m[uidx] = (pht_m[uidx] == 3) ? 3 : pht_m[uidx] + 1;
                else    pht_m[uidx] = (pht_m[uidx] == 0) ? 0 : pht_m[uidx] - 1;
            end
            if (uv && ut) begin
                ubidx         = (upc / 4) % 64;
                bv_m[ubidx]   = 1;
                btag_m[ubidx] = upc / 256;
                btgt_m[ubidx] = utg;
                bu_m[ubidx]   = !uc;
            end
            if (uv && um)
                ghr_m = uc ? ((ug * 2 + ut) % 256) : ug;
            else if (e && m_hit && !bu_m_old(bidx, m_hit, m_taken, pidx))
                ghr_m = (ghr_m * 2 + m_taken) % 256;
        end
        #1;
    endtask

    // Captured before the BTB model is rewritten within the same cycle.
    bit uncond_snap;
    function automatic bit bu_m_old(int unsigned bidx, bit hit, bit taken, int unsigned pidx);
        return uncond_snap;
    endfunction

    task automatic step(input bit r, input bit e, input logic [31:0] pc,
                        input bit uv, input logic [31:0] upc, input bit uc, input bit ut,
                        input logic [31:0] utg, input logic [7:0] ug, input bit um);
        uncond_snap = bu_m[(pc / 4) % 64];
        cyc(r, e, pc, uv, upc, uc, ut, utg, ug, um);
    endtask

    task automatic look(input bit e, input logic [31:0] pc);
        step(0, e, pc, 0, 32'h0, 0, 0, 32'h0, 8'h0, 0);
    endtask

    logic [31:0] bases [4];

    initial begin
        bases[0] = 32'h1000; bases[1] = 32'h1100; bases[2] = 32'h2000; bases[3] = 32'h0300;

        // Reset
        step(1, 0, 32'h100, 0, 32'h0, 0, 0, 32'h0, 8'h0, 0);
        look(1, 32'h100);
        chk("rst_taken", 64'(obs_taken), 64'd0);
        chk("rst_pc",    64'(obs_pc),    64'h104);
        chk("rst_ghr",   64'(obs_ghr),   64'd0);

        // Jump learning
        step(0, 1, 32'h100, 1, 32'h200, 0, 1, 32'h400, 8'h0, 0);
        look(1, 32'h200);
        chk("jmp_taken", 64'(obs_taken), 64'd1);
        chk("jmp_pc",    64'(obs_pc),    64'h400);
        look(1, 32'h100);
        chk("jmp_noshift", 64'(obs_ghr), 64'd0);

        // Counter saturation with history held at zero
        for (int i = 0; i < 3; i++) step(0, 0, 32'h100, 1, 32'h300, 1, 1, 32'h500, 8'h0, 0);
        look(0, 32'h300);
        chk("sat_pc", 64'(obs_pc), 64'h500);
        step(0, 0, 32'h300, 1, 32'h300, 1, 0, 32'h500, 8'h0, 0);
        step(0, 0, 32'h300, 1, 32'h300, 1, 0, 32'h500, 8'h0, 0);
        chk("weak_taken_pc", 64'(obs_pc), 64'h500);
        look(0, 32'h300);
        chk("weak_nt_pc", 64'(obs_pc), 64'h304);

        // Speculative shift
        step(0, 0, 32'h100, 1, 32'h300, 1, 1, 32'h500, 8'h05, 0);
        step(0, 0, 32'h100, 1, 32'h2040, 0, 1, 32'h3000, 8'h05, 1);
        look(0, 32'h300);
        chk("spec_taken", 64'(obs_taken), 64'd1);
        chk("spec_ghr0",  64'(obs_ghr),   64'h05);
        look(0, 32'h300);
        chk("stall_ghr", 64'(obs_ghr), 64'h05);
        look(1, 32'h300);
        look(0, 32'h100);
        chk("shift_ghr", 64'(obs_ghr), 64'h0B);

        // Repair priority over a same-cycle speculative shift
        step(0, 1, 32'h300, 1, 32'h704, 1, 1, 32'h900, 8'h80, 1);
        look(0, 32'h100);
        chk("repair_ghr", 64'(obs_ghr), 64'h01);

        // Aliasing: same BTB index, different tag
        step(0, 0, 32'h100, 1, 32'h1000, 0, 1, 32'h1800, 8'h0, 0);
        look(0, 32'h1100);
        chk("alias_taken", 64'(obs_taken), 64'd0);
        chk("alias_pc",    64'(obs_pc),    64'h1104);
        look(0, 32'h1000);
        chk("alias_hit_pc", 64'(obs_pc), 64'h1800);

        // Randomized traffic over a small PC pool so entries collide and retrain
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc, upc, tgt;
            pc  = bases[$urandom_range(0, 3)] + 32'(4 * $urandom_range(0, 15));
            upc = bases[$urandom_range(0, 3)] + 32'(4 * $urandom_range(0, 15));
            tgt = $urandom & 32'hFFFF_FFFC;
            step($urandom_range(0, 255) == 0, 1'($urandom), pc,
                 $urandom_range(0, 2) != 0, upc, $urandom_range(0, 3) != 0, 1'($urandom),
                 tgt, 8'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
